// File: rtl/dpll_div_ctrl_if.sv
// rtl/dpll_div_ctrl_if.sv - divider-side link between the DPLL loop controller and the programmable divider
//
// Signals:
//   div_factor  controller -> divider  current divide ratio
//   div_load    controller -> divider  1-cycle strobe, divider latches div_factor
//   div_wrap    divider -> controller  1-cycle pulse at each output-period boundary
//
// Modports:
//   master  loop controller side
//   slave   divider side
interface dpll_div_ctrl_if #(
    parameter int DIV_W = 10
) ();
    logic [DIV_W-1:0] div_factor;
    logic             div_load;
    logic             div_wrap;

    modport master (
        output div_factor,
        output div_load,
        input  div_wrap
    );

    modport slave (
        input  div_factor,
        input  div_load,
        output div_wrap
    );
endinterface

// File: rtl/dpll_div_ctrl.sv
// rtl/dpll_div_ctrl.sv - DPLL loop controller: K-counter filter, boundary-aligned divide-ratio updates, lock detect
//
// Runs in the divider input clock domain. Phase-detector up/down pulses are
// filtered by a bidirectional K-counter; each overflow posts a single-entry
// +/-1 divide-ratio request that is handed to the divider only at a period
// boundary (div_wrap). Lock is declared after LOCK_CNT consecutive
// correction-free divider periods.
//
// Optional build macro: DPLL_HOLDOVER_EN adds the holdover_i input, which
// freezes the loop (no filtering, no corrections, lock state held).
//
// Ports:
//   clk         in   divider input clock
//   rst_n       in   asynchronous active-low reset
//   enable_i    in   loop enable; low forces IDLE and restores NOM_DIV
//   pd_up_i     in   phase detector "output late" pulse
//   pd_dn_i     in   phase detector "output early" pulse
//   holdover_i  in   (DPLL_HOLDOVER_EN only) freeze the loop
//   div_if      master modport: div_factor/div_load out, div_wrap in
//   locked_o    out  loop locked flag
//   state_o     out  FSM state: 0 IDLE, 1 ACQUIRE, 2 LOCKED
module dpll_div_ctrl #(
    parameter int NOM_DIV  = 5,
    parameter int DIV_MIN  = 2,
    parameter int DIV_MAX  = 1023,
    parameter int DIV_W    = 10,
    parameter int K_TOP    = 8,
    parameter int LOCK_CNT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable_i,
    input  logic                   pd_up_i,
    input  logic                   pd_dn_i,
`ifdef DPLL_HOLDOVER_EN
    input  logic                   holdover_i,
`endif
    dpll_div_ctrl_if.master        div_if,
    output logic                   locked_o,
    output logic [1:0]             state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_FAST = 2'd1,   // shorten period: div - 1
        REQ_SLOW = 2'd2    // lengthen period: div + 1
    } req_t;

    // K_TOP is at most 127, so 8 signed bits cover -K_TOP..+K_TOP.
    localparam int LCW = $clog2(LOCK_CNT + 1);

    localparam logic signed [7:0]   K_POS    = 8'(K_TOP);
    localparam logic signed [7:0]   K_NEG    = -K_POS;
    localparam logic [DIV_W-1:0]    NOM_F    = DIV_W'(NOM_DIV);
    localparam logic [DIV_W-1:0]    MIN_F    = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0]    MAX_F    = DIV_W'(DIV_MAX);
    localparam logic [LCW-1:0]      LOCK_MAX = LCW'(LOCK_CNT);

    state_t            state_q, state_d;
    logic signed [7:0] k_q, k_d;
    req_t              pend_q, pend_d;
    logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [DIV_W-1:0]  div_factor_q, div_factor_d;
    logic              div_load_q, div_load_d;
    logic              locked_q, locked_d;

    logic              hold;
    logic signed [7:0] k_step;
    logic signed [7:0] k_sum;
    req_t              new_req;
    req_t              pend_base;
    logic              apply;
    logic              blocked;
    logic              correct;

`ifdef DPLL_HOLDOVER_EN
    assign hold = holdover_i;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        pend_d       = pend_q;
        lock_cnt_d   = lock_cnt_q;
        div_factor_d = div_factor_q;
        div_load_d   = 1'b0;
        k_sum        = k_q;
        new_req      = REQ_NONE;
        pend_base    = pend_q;
        apply        = 1'b0;
        blocked      = 1'b0;
        correct      = 1'b0;

        // Simultaneous up and down cancel each other.
        if (pd_up_i && !pd_dn_i) begin
            k_step = 8'sd1;
        end else if (pd_dn_i && !pd_up_i) begin
            k_step = -8'sd1;
        end else begin
            k_step = 8'sd0;
        end

        if (!enable_i) begin
            // Disable restores the nominal ratio immediately, without
            // waiting for a period boundary.
            state_d    = S_IDLE;
            k_d        = '0;
            pend_d     = REQ_NONE;
            lock_cnt_d = '0;
            if (div_factor_q != NOM_F) begin
                div_factor_d = NOM_F;
                div_load_d   = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_ACQUIRE;
                    k_d        = '0;
                    pend_d     = REQ_NONE;
                    lock_cnt_d = '0;
                end

                S_ACQUIRE, S_LOCKED: begin
                    if (hold) begin
                        // Loop frozen; K restarts from zero when released.
                        k_d    = '0;
                        pend_d = REQ_NONE;
                    end else begin
                        // Only a request already registered before this
                        // wrap is eligible; one posted now waits a period.
                        apply   = div_if.div_wrap && (pend_q != REQ_NONE);
                        blocked = ((pend_q == REQ_FAST) && (div_factor_q == MIN_F)) ||
                                  ((pend_q == REQ_SLOW) && (div_factor_q == MAX_F));
                        correct = apply && !blocked;

                        if (correct) begin
                            div_load_d = 1'b1;
                            if (pend_q == REQ_FAST) begin
                                div_factor_d = div_factor_q - DIV_W'(1);
                            end else begin
                                div_factor_d = div_factor_q + DIV_W'(1);
                            end
                        end

                        // A saturated request is consumed without effect.
                        pend_base = apply ? REQ_NONE : pend_q;

                        k_sum = k_q + k_step;
                        if (k_sum == K_POS) begin
                            k_d     = '0;
                            new_req = REQ_FAST;
                        end else if (k_sum == K_NEG) begin
                            k_d     = '0;
                            new_req = REQ_SLOW;
                        end else begin
                            k_d = k_sum;
                        end

                        // Single-entry slot: same direction is dropped,
                        // opposite direction annihilates the pending one.
                        if (new_req == REQ_NONE) begin
                            pend_d = pend_base;
                        end else if (pend_base == REQ_NONE) begin
                            pend_d = new_req;
                        end else if (pend_base == new_req) begin
                            pend_d = pend_base;
                        end else begin
                            pend_d = REQ_NONE;
                        end

                        if (correct) begin
                            lock_cnt_d = '0;
                        end else if (div_if.div_wrap && (lock_cnt_q != LOCK_MAX)) begin
                            lock_cnt_d = lock_cnt_q + LCW'(1);
                        end

                        if (correct) begin
                            state_d = S_ACQUIRE;
                        end else if ((state_q == S_ACQUIRE) && (lock_cnt_d == LOCK_MAX)) begin
                            state_d = S_LOCKED;
                        end
                    end
                end

                default: begin
                    state_d    = S_IDLE;
                    k_d        = '0;
                    pend_d     = REQ_NONE;
                    lock_cnt_d = '0;
                end
            endcase
        end

        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            pend_q       <= REQ_NONE;
            lock_cnt_q   <= '0;
            div_factor_q <= NOM_F;
            div_load_q   <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            pend_q       <= pend_d;
            lock_cnt_q   <= lock_cnt_d;
            div_factor_q <= div_factor_d;
            div_load_q   <= div_load_d;
            locked_q     <= locked_d;
        end
    end

    assign div_if.div_factor = div_factor_q;
    assign div_if.div_load   = div_load_q;
    assign locked_o          = locked_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_dpll_div_ctrl.sv
// tb/tb_dpll_div_ctrl.sv - directed scoreboard bench for dpll_div_ctrl
module tb_dpll_div_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       pd_up;
    logic       pd_dn;
    logic       locked;
    logic [1:0] state;
`ifdef DPLL_HOLDOVER_EN
    logic       holdover;
`endif

    int checks = 0;
    int errors = 0;
    int load_q[$];
    int exp_factor;

    dpll_div_ctrl_if #(.DIV_W(10)) dif ();

    dpll_div_ctrl #(
        .NOM_DIV (5),
        .DIV_MIN (2),
        .DIV_MAX (1023),
        .DIV_W   (10),
        .K_TOP   (8),
        .LOCK_CNT(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (enable),
        .pd_up_i   (pd_up),
        .pd_dn_i   (pd_dn),
`ifdef DPLL_HOLDOVER_EN
        .holdover_i(holdover),
`endif
        .div_if    (dif),
        .locked_o  (locked),
        .state_o   (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive one pd direction for n consecutive cycles.
    task automatic pulses(input bit up, input int n);
        pd_up = up;
        pd_dn = !up;
        repeat (n) tick();
        pd_up = 1'b0;
        pd_dn = 1'b0;
    endtask

    // One div_wrap cycle; a non-negative exp_load is the div_factor the
    // scoreboard expects with the div_load strobe one cycle later.
    task automatic wrap(input int exp_load);
        if (exp_load >= 0) begin
            load_q.push_back(exp_load);
            exp_factor = exp_load;
        end
        dif.div_wrap = 1'b1;
        tick();
        dif.div_wrap = 1'b0;
    endtask

    // Every div_load strobe must match the oldest expected load.
    always @(negedge clk) begin
        if (dif.div_load !== 1'b0) begin
            if (load_q.size() == 0) begin
                chk("unexpected_load", 32'(dif.div_load), 32'd0);
            end else begin
                chk("load_factor", 32'(dif.div_factor), 32'(load_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        pd_up        = 1'b0;
        pd_dn        = 1'b0;
        dif.div_wrap = 1'b0;
`ifdef DPLL_HOLDOVER_EN
        holdover     = 1'b0;
`endif
        exp_factor   = 5;

        tick();
        tick();
        chk("rst_factor", 32'(dif.div_factor), 32'd5);
        chk("rst_load",   32'(dif.div_load),   32'd0);
        chk("rst_locked", 32'(locked),         32'd0);
        chk("rst_state",  32'(state),          32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold_state", 32'(state), 32'd0);

        enable = 1'b1;
        tick();
        chk("acq_state", 32'(state), 32'd1);

        // 16 quiet periods -> lock one cycle after the 16th wrap
        for (int i = 0; i < 15; i++) wrap(-1);
        chk("pre_lock_state",  32'(state),  32'd1);
        chk("pre_lock_locked", 32'(locked), 32'd0);
        wrap(-1);
        chk("lock_state",  32'(state),          32'd2);
        chk("lock_locked", 32'(locked),         32'd1);
        chk("lock_factor", 32'(dif.div_factor), 32'd5);

        // FAST correction from LOCKED
        pulses(1'b1, 8);
        chk("fast_pending_still_locked", 32'(state), 32'd2);
        wrap(4);
        chk("fast_factor", 32'(dif.div_factor), 32'd4);
        chk("fast_locked", 32'(locked),         32'd0);
        chk("fast_state",  32'(state),          32'd1);

        // SLOW correction back to nominal
        pulses(1'b0, 8);
        wrap(5);
        chk("slow_factor", 32'(dif.div_factor), 32'd5);

        // Opposite request cancels the pending one
        pulses(1'b1, 8);
        pulses(1'b0, 8);
        wrap(-1);
        tick();
        chk("cancel_factor", 32'(dif.div_factor), 32'(exp_factor));

        // Simultaneous up/down holds K
        pd_up = 1'b1;
        pd_dn = 1'b1;
        repeat (20) tick();
        pd_up = 1'b0;
        pd_dn = 1'b0;
        wrap(-1);
        tick();
        chk("both_factor", 32'(dif.div_factor), 32'd5);

        // Request posted on a wrap cycle waits for the next wrap
        pulses(1'b1, 7);
        pd_up        = 1'b1;
        dif.div_wrap = 1'b1;
        tick();
        pd_up        = 1'b0;
        dif.div_wrap = 1'b0;
        tick();
        chk("late_post_factor", 32'(dif.div_factor), 32'd5);
        wrap(4);
        chk("late_post_applied", 32'(dif.div_factor), 32'd4);

        // Walk down to DIV_MIN
        pulses(1'b1, 8);
        wrap(3);
        pulses(1'b1, 8);
        wrap(2);
        chk("min_factor", 32'(dif.div_factor), 32'd2);

        // FAST at DIV_MIN is discarded but the period still counts
        pulses(1'b1, 8);
        wrap(-1);
        tick();
        chk("sat_factor", 32'(dif.div_factor), 32'd2);
        for (int i = 0; i < 14; i++) wrap(-1);
        chk("sat_cnt15_state", 32'(state), 32'd1);
        wrap(-1);
        chk("sat_cnt16_state", 32'(state), 32'd2);

        // Walk up to 7
        for (int v = 3; v <= 7; v++) begin
            pulses(1'b0, 8);
            wrap(v);
        end
        chk("seven_factor", 32'(dif.div_factor), 32'd7);

        // Disable restores nominal without a wrap
        load_q.push_back(5);
        enable = 1'b0;
        tick();
        chk("dis_factor", 32'(dif.div_factor), 32'd5);
        chk("dis_load",   32'(dif.div_load),   32'd1);
        chk("dis_state",  32'(state),          32'd0);
        chk("dis_locked", 32'(locked),         32'd0);
        tick();
        chk("dis_load_pulse", 32'(dif.div_load), 32'd0);

        // IDLE ignores pd and wrap
        pulses(1'b1, 10);
        wrap(-1);
        tick();
        chk("idle_ignore_state",  32'(state),          32'd0);
        chk("idle_ignore_factor", 32'(dif.div_factor), 32'd5);

        // Disable at nominal: no strobe
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        chk("dis_nom_state", 32'(state), 32'd0);
        tick();

        // Async reset with a request pending
        enable = 1'b1;
        tick();
        pulses(1'b1, 8);
        wrap(4);
        chk("pre_rst_factor", 32'(dif.div_factor), 32'd4);
        pulses(1'b1, 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_factor", 32'(dif.div_factor), 32'd5);
        chk("arst_load",   32'(dif.div_load),   32'd0);
        chk("arst_locked", 32'(locked),         32'd0);
        chk("arst_state",  32'(state),          32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_state", 32'(state), 32'd1);
        wrap(-1);
        tick();
        chk("post_rst_factor", 32'(dif.div_factor), 32'd5);

        tick();
        chk("scoreboard_drained", 32'(load_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
